// File: rtl/core_run_controller.sv
// Run/halt sequencer for the JZJCoreF core: owns core reset and clock-enable,
// accepts debug commands, and stops the core on a single hardware breakpoint.
module core_run_controller #(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter bit START_RUNNING     = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdOp,
  input  logic [31:0] cmdData,
  input  logic [31:0] pcOfInstruction,
  output logic        coreReset,
  output logic        coreEnable,
  output logic        halted,
  output logic        bpHit,
  output logic [31:0] stepCount
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES - 1);

  localparam logic [2:0] OP_RUN        = 3'd1;
  localparam logic [2:0] OP_HALT       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_BP     = 3'd4;
  localparam logic [2:0] OP_CLR_BP     = 3'd5;
  localparam logic [2:0] OP_RESET_CORE = 3'd6;

  typedef enum logic [1:0] {
    S_RESETTING = 2'd0,
    S_HALTED    = 2'd1,
    S_RUNNING   = 2'd2,
    S_STEPPING  = 2'd3
  } state_t;

  state_t             r_state;
  logic [HOLD_W-1:0]  r_hold;
  logic [15:0]        r_stepLeft;
  logic               r_bpValid;
  logic [31:0]        r_bpAddr;
  logic               r_bpHit;
  logic               r_skipBp;
  logic [31:0]        r_stepCount;
  logic               r_cmdReady;
  logic               r_coreReset;
  logic               r_halted;

  state_t             w_nextState;
  logic               w_accept;
  logic               w_bpMatch;
  logic               w_active;
  logic               w_coreEnable;
  logic               w_resetCore;
  logic               w_resume;
  logic [15:0]        w_stepLoad;

  // Breakpoint compare is combinational so the matching instruction never gets enabled.
  assign w_bpMatch    = r_bpValid && (pcOfInstruction == r_bpAddr) && !r_skipBp;
  assign w_active     = (r_state == S_RUNNING) || (r_state == S_STEPPING);
  assign w_coreEnable = w_active && !w_bpMatch;
  assign w_accept     = cmdValid && r_cmdReady;
  assign w_resetCore  = w_accept && (cmdOp == OP_RESET_CORE);
  assign w_resume     = w_accept && ((cmdOp == OP_RUN) || (cmdOp == OP_STEP));
  assign w_stepLoad   = (cmdData[15:0] == 16'd0) ? 16'd1 : cmdData[15:0];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_RESETTING: begin
        if (r_hold == '0) w_nextState = START_RUNNING ? S_RUNNING : S_HALTED;
      end
      S_HALTED: begin
        if (w_accept) begin
          case (cmdOp)
            OP_RUN:        w_nextState = S_RUNNING;
            OP_STEP:       w_nextState = S_STEPPING;
            OP_RESET_CORE: w_nextState = S_RESETTING;
            default:       w_nextState = S_HALTED;
          endcase
        end
      end
      S_RUNNING: begin
        if (w_resetCore)                                   w_nextState = S_RESETTING;
        else if (w_bpMatch || (w_accept && cmdOp == OP_HALT)) w_nextState = S_HALTED;
      end
      S_STEPPING: begin
        // A breakpoint stop or consumption of the last step both land in HALTED.
        if (w_bpMatch || (r_stepLeft == 16'd1)) w_nextState = S_HALTED;
      end
      default: w_nextState = S_RESETTING;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RESETTING;
      r_hold      <= HOLD_INIT;
      r_stepLeft  <= 16'd0;
      r_bpValid   <= 1'b0;
      r_bpAddr    <= 32'd0;
      r_bpHit     <= 1'b0;
      r_skipBp    <= 1'b0;
      r_stepCount <= 32'd0;
      r_cmdReady  <= 1'b0;
      r_coreReset <= 1'b1;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_coreReset <= (w_nextState == S_RESETTING);
      r_cmdReady  <= (w_nextState == S_HALTED) || (w_nextState == S_RUNNING);
      r_halted    <= (w_nextState == S_HALTED);

      if (w_resetCore)                                   r_hold <= HOLD_INIT;
      else if (r_state == S_RESETTING && r_hold != '0)   r_hold <= r_hold - HOLD_W'(1);

      if (r_state == S_HALTED && w_accept && cmdOp == OP_STEP) r_stepLeft <= w_stepLoad;
      else if (r_state == S_STEPPING && w_coreEnable)          r_stepLeft <= r_stepLeft - 16'd1;

      // skipBp lets a resume execute the instruction sitting on the breakpoint once.
      if (w_resetCore)                             r_skipBp <= 1'b0;
      else if (r_state == S_HALTED && w_resume)    r_skipBp <= 1'b1;
      else if (w_coreEnable)                       r_skipBp <= 1'b0;

      if (w_accept && cmdOp == OP_SET_BP) begin
        r_bpAddr  <= cmdData;
        r_bpValid <= 1'b1;
      end else if (w_accept && cmdOp == OP_CLR_BP) begin
        r_bpValid <= 1'b0;
      end

      if (w_resetCore)                 r_bpHit <= 1'b0;
      else if (w_active && w_bpMatch)  r_bpHit <= 1'b1;
      else if (w_resume)               r_bpHit <= 1'b0;

      if (w_resetCore)       r_stepCount <= 32'd0;
      else if (w_coreEnable) r_stepCount <= r_stepCount + 32'd1;
    end
  end

  assign cmdReady   = r_cmdReady;
  assign coreReset  = r_coreReset;
  assign coreEnable = w_coreEnable;
  assign halted     = r_halted;
  assign bpHit      = r_bpHit;
  assign stepCount  = r_stepCount;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller with a simple core PC model (+4 per enabled cycle).
module tb_core_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [2:0]  cmdOp;
  logic [31:0] cmdData;
  logic [31:0] pcOfInstruction;
  logic        coreReset;
  logic        coreEnable;
  logic        halted;
  logic        bpHit;
  logic [31:0] stepCount;

  logic [31:0] pc = 32'd0;
  int total = 0;
  int bad   = 0;

  core_run_controller #(.RESET_HOLD_CYCLES(4), .START_RUNNING(1'b0)) dut (
    .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdData(cmdData), .pcOfInstruction(pcOfInstruction),
    .coreReset(coreReset), .coreEnable(coreEnable), .halted(halted),
    .bpHit(bpHit), .stepCount(stepCount)
  );

  always #5 clock = ~clock;

  // Core PC model: cleared while in reset, advances one instruction per enabled cycle.
  always @(posedge clock) begin
    if (coreReset === 1'b1)       pc <= 32'd0;
    else if (coreEnable === 1'b1) pc <= pc + 32'd4;
  end
  assign pcOfInstruction = pc;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdData  = d;
    tick();
    cmdValid = 1'b0;
    cmdOp    = 3'd0;
    cmdData  = 32'd0;
  endtask

  task automatic count_reset(output int n);
    n = 0;
    while (coreReset === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_halted(input int lim, output int en);
    en = 0;
    for (int i = 0; i < lim && halted !== 1'b1; i++) begin
      if (coreEnable === 1'b1) en++;
      tick();
    end
  endtask

  initial begin
    int n;
    int en;
    int rdyLow;
    reset    = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = 3'd0;
    cmdData  = 32'd0;
    tick();

    // Reset values
    chk1("rst_coreReset", coreReset, 1'b1);
    chk1("rst_coreEnable", coreEnable, 1'b0);
    chk1("rst_cmdReady", cmdReady, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_bpHit", bpHit, 1'b0);
    chk32("rst_stepCount", stepCount, 32'd0);
    reset = 1'b0;

    count_reset(n);
    chk32("rst_hold_cycles", n, 32'd4);
    chk1("post_rst_halted", halted, 1'b1);
    chk1("post_rst_coreEnable", coreEnable, 1'b0);
    chk1("post_rst_cmdReady", cmdReady, 1'b1);
    chk32("post_rst_stepCount", stepCount, 32'd0);

    // STEP 5
    send(3'd3, 32'd5);
    en = 0; rdyLow = 0;
    for (int i = 0; i < 20 && halted !== 1'b1; i++) begin
      if (coreEnable === 1'b1) en++;
      if (cmdReady === 1'b0) rdyLow++;
      tick();
    end
    chk32("step5_enabled", en, 32'd5);
    chk32("step5_rdy_low", rdyLow, 32'd5);
    chk32("step5_stepCount", stepCount, 32'd5);
    chk1("step5_halted", halted, 1'b1);

    // STEP 0 behaves as STEP 1
    send(3'd3, 32'd0);
    wait_halted(20, en);
    chk32("step0_enabled", en, 32'd1);
    chk32("step0_stepCount", stepCount, 32'd6);

    // RESET_CORE from HALTED to restart the PC model at 0
    send(3'd6, 32'd0);
    count_reset(n);
    chk32("rc_halted_hold", n, 32'd4);
    chk32("rc_halted_stepCount", stepCount, 32'd0);

    // Breakpoint at 0x10: PCs 0,4,8,C execute, 0x10 is blocked
    send(3'd4, 32'h10);
    chk1("setbp_still_halted", halted, 1'b1);
    send(3'd1, 32'd0);
    for (int i = 0; i < 20 && halted !== 1'b1; i++) begin
      if (pcOfInstruction == 32'h10) chk1("bp_en_low", coreEnable, 1'b0);
      tick();
    end
    chk1("bp_hit", bpHit, 1'b1);
    chk1("bp_halted", halted, 1'b1);
    chk32("bp_stepCount", stepCount, 32'd4);
    chk32("bp_pc", pcOfInstruction, 32'h10);

    // Resume: instruction at 0x10 executes once
    send(3'd1, 32'd0);
    chk1("resume_en", coreEnable, 1'b1);
    chk1("resume_bpHit_clr", bpHit, 1'b0);
    chk1("resume_not_halted", halted, 1'b0);
    tick();
    chk32("resume_pc", pcOfInstruction, 32'h14);
    chk32("resume_stepCount", stepCount, 32'd5);

    // HALT accepted in cycle t: enable high in t, low from t+1
    cmdValid = 1'b1; cmdOp = 3'd2; cmdData = 32'd0;
    chk1("halt_en_in_t", coreEnable, 1'b1);
    tick();
    cmdValid = 1'b0; cmdOp = 3'd0;
    chk1("halt_en_t1", coreEnable, 1'b0);
    chk1("halt_halted", halted, 1'b1);
    tick();
    chk32("halt_stepCount", stepCount, 32'd6);

    // RESET_CORE while RUNNING keeps the breakpoint
    send(3'd1, 32'd0);
    chk1("run2_en", coreEnable, 1'b1);
    send(3'd6, 32'd0);
    chk1("rc_run_coreReset", coreReset, 1'b1);
    chk32("rc_run_stepCount", stepCount, 32'd0);
    count_reset(n);
    chk32("rc_run_hold", n, 32'd4);
    chk1("rc_run_halted", halted, 1'b1);
    send(3'd1, 32'd0);
    wait_halted(20, en);
    chk1("bp_kept_hit", bpHit, 1'b1);
    chk32("bp_kept_stepCount", stepCount, 32'd4);
    chk32("bp_kept_pc", pcOfInstruction, 32'h10);

    // Reset in the middle of STEP 10
    send(3'd3, 32'd10);
    tick();
    chk1("mid_step_en", coreEnable, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("mid_rst_coreReset", coreReset, 1'b1);
    chk1("mid_rst_coreEnable", coreEnable, 1'b0);
    chk32("mid_rst_stepCount", stepCount, 32'd0);
    chk1("mid_rst_bpHit", bpHit, 1'b0);
    count_reset(n);
    chk32("mid_rst_hold", n, 32'd4);
    tick(); tick();
    chk32("mid_rst_no_enable", stepCount, 32'd0);
    chk1("mid_rst_halted", halted, 1'b1);

    // Breakpoint was cleared by reset: running from 0 passes 0x10
    send(3'd1, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk1("bpclr_rst_running", halted, 1'b0);
    chk32("bpclr_rst_stepCount", stepCount, 32'd8);
    chk32("bpclr_rst_pc", pcOfInstruction, 32'h20);

    // SET_BP then CLR_BP while running: no stop at 0x40
    send(3'd4, 32'h40);
    send(3'd5, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk1("clrbp_not_halted", halted, 1'b0);
    chk1("clrbp_no_hit", bpHit, 1'b0);
    chk32("clrbp_stepCount", stepCount, 32'd20);
    chk32("clrbp_pc", pcOfInstruction, 32'h50);
    send(3'd2, 32'd0);
    chk1("clrbp_halt", halted, 1'b1);

    // Counter wrap
    force dut.r_stepCount = 32'hFFFF_FFFF;
    tick();
    release dut.r_stepCount;
    send(3'd3, 32'd1);
    wait_halted(20, en);
    chk32("wrap_enabled", en, 32'd1);
    chk32("wrap_stepCount", stepCount, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
